// File: rtl/shift_right_iter_32.sv
// Iterative right shifter: one bit position per clock under a start/done
// handshake. Supports logical (zero fill) and arithmetic (sign fill) shifts.
// Latency is shamt+1 cycles from the accepting edge to the done pulse.
module shift_right_iter_32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [SHAMT_W-1:0] count_reg;
  logic               arith_reg;

  logic               fill;
  logic [WIDTH-1:0]   shift_next;

  // The MSB stays put under an arithmetic shift, so it is always the original sign.
  assign fill = arith_reg ? data_reg[WIDTH-1] : 1'b0;

  // One-position right shift of the working register.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shift_next[gi] = data_reg[gi+1];
    end
  endgenerate
  assign shift_next[WIDTH-1] = fill;

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      count_reg <= '0;
      arith_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            data_reg  <= data_i;
            count_reg <= shamt_i;
            arith_reg <= arith_i;
            state_reg <= (shamt_i != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          data_reg  <= shift_next;
          count_reg <= count_reg - SHAMT_W'(1);
          if (count_reg == SHAMT_W'(1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers or state decode only.
  assign data_o = data_reg;
  assign busy_o = (state_reg != IDLE);
  assign done_o = (state_reg == DONE);

endmodule

// File: tb/tb_shift_right_iter_32.sv
// Bench for shift_right_iter_32: directed cases plus randomized operations
// checked against a plain-arithmetic reference shift.
module tb_shift_right_iter_32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        arith_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  shift_right_iter_32 #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  // Runs one operation starting at the current negedge (state must be IDLE).
  // With disturb set, start_i stays high with junk operands while busy.
  task automatic do_op(input logic [31:0] d, input int s, input logic a, input logic disturb);
    logic [31:0] exp;
    int c;
    int n_busy;
    exp = ref_shift(d, s, a);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = 5'(s);
    arith_i = a;
    @(posedge clk_i);
    #1;
    if (disturb) begin
      data_i  = $urandom;
      shamt_i = 5'($urandom_range(0, 31));
      arith_i = 1'($urandom_range(0, 1));
    end else begin
      start_i = 1'b0;
    end
    n_busy = 0;
    c = 0;
    while (c < 64) begin
      @(negedge clk_i);
      c++;
      if (busy_o) n_busy++;
      if (disturb) data_i = $urandom;
      if (done_o) break;
    end
    $display("op data=0x%08h shamt=%0d arith=%0d disturb=%0d -> data_o=0x%08h latency=%0d",
             d, s, a, disturb, data_o, c);
    chk("latency", 32'(c), 32'(s + 1));
    chk("result", data_o, exp);
    chk("busy_cycles", 32'(n_busy), 32'(s + 1));
    start_i = 1'b0;
    @(negedge clk_i);
    chk("done_pulse_len", {31'b0, done_o}, 32'd0);
    chk("busy_after", {31'b0, busy_o}, 32'd0);
    chk("result_held", data_o, exp);
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    data_i  = 32'hDEAD_BEEF;
    shamt_i = 5'd3;
    arith_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("reset_data", data_o, 32'd0);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_done", {31'b0, done_o}, 32'd0);

    // Directed cases
    do_op(32'h8000_0000, 5, 1'b0, 1'b0);
    do_op(32'h8000_0000, 4, 1'b1, 1'b0);
    do_op(32'h8000_0001, 31, 1'b1, 1'b0);
    do_op(32'h8000_0001, 31, 1'b0, 1'b0);
    do_op(32'h1234_5678, 0, 1'b0, 1'b0);
    do_op(32'h0ABC_DEF1 << 2, 2, 1'b0, 1'b0);
    chk("round_trip", data_o, 32'h0ABC_DEF1);
    do_op(32'hF0F0_1234, 7, 1'b1, 1'b1);
    do_op(32'h7FFF_FFFF, 0, 1'b1, 1'b1);

    // Randomized back-to-back operations
    for (int i = 0; i < 40; i++) begin
      do_op($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
    end

    // Reset mid-shift aborts without a done pulse
    start_i = 1'b1;
    data_i  = 32'hCAFE_F00D;
    shamt_i = 5'd20;
    arith_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("mid_busy", {31'b0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    $display("mid-shift reset -> data_o=0x%08h busy=%0d done=%0d", data_o, busy_o, done_o);
    chk("abort_data", data_o, 32'd0);
    chk("abort_busy", {31'b0, busy_o}, 32'd0);
    chk("abort_done", {31'b0, done_o}, 32'd0);
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (25) begin
        @(negedge clk_i);
        if (done_o) seen_done = 1'b1;
      end
      chk("no_done_after_abort", {31'b0, seen_done}, 32'd0);
    end
    do_op(32'h0000_0F00, 8, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_right_iter_32.md
Name: shift_right_iter_32

Overview:
- Multi-cycle right shifter for the multicycle datapath; the counterpart to the combinational left-shift-by-two block.
- Serves SRL/SRA and byte-offset-to-word-index conversion.
- Shifts one bit position per clock under a start/done handshake, which keeps area low at the cost of variable latency (shamt+1 cycles).
- Sits beside the ALU. The controller holds its FSM in the execute state until done_o is asserted.

Parameters:
- WIDTH, 32, data path width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- data_i  in  WIDTH  operand; captured with start.
- shamt_i  in  SHAMT_W  shift amount, 0..WIDTH-1; captured with start.
- arith_i  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured with start.
- data_o  out  WIDTH  working/result register; valid when done_o=1 and held until the next accepted start.
- busy_o  out  1  high in SHIFT and DONE.
- done_o  out  1  one-cycle pulse; result valid.

Behaviour:
- Reset (rst_i=1 at a rising edge) gives:
  - state=IDLE
  - data_o=0, busy_o=0, done_o=0
  - internal count=0, arith flag=0
- Reset overrides everything, including mid-operation. The operation is aborted with no done pulse, and the result is discarded.
- States: IDLE, SHIFT, DONE. Outputs are registered or state-decoded only; there is no combinational path from inputs to outputs.
- IDLE:
  - start_i=1 loads data_reg<=data_i, count<=shamt_i, arith<=arith_i.
  - Next state is SHIFT if shamt_i!=0, otherwise DONE.
  - start_i=0 stays in IDLE and holds data_reg.
- SHIFT, each cycle:
  - data_reg <= {fill, data_reg[WIDTH-1:1]}, where fill = arith ? data_reg[WIDTH-1] : 1'b0.
  - count <= count-1.
  - When count==1 (last shift), next state is DONE.
- DONE:
  - done_o=1 for exactly this cycle; next state is IDLE unconditionally.
- start_i handling:
  - Ignored in SHIFT and DONE; operands are not re-captured.
  - Back-to-back throughput: a new start is accepted no earlier than the cycle after DONE.
- Latency:
  - If start is sampled at edge k, done_o is high in the cycle following edge k+shamt.
  - shamt=0 gives done one cycle after start; shamt=31 gives done 32 cycles after start.
- busy_o = (state != IDLE).
- data_o = data_reg:
  - Intermediate values are visible during SHIFT and must not be consumed.
  - Holds its value in IDLE after DONE until the next accepted start.
- Arithmetic rules:
  - The sign bit used for fill is the current MSB of data_reg, equivalent to the original sign because the MSB is preserved under arithmetic shift.
  - No overflow is possible.
  - shamt_i is unsigned; it is never masked or clamped beyond its SHAMT_W width.
- X-safety: data_i, shamt_i and arith_i are don't-care unless start_i=1 in IDLE.

Test Plan:
- Logical shift: data_i=0x80000000, shamt=5, arith=0 -> done_o pulses 6 cycles after start, data_o=0x04000000, busy_o high for exactly 6 cycles.
- Arithmetic shift: data_i=0x80000000, shamt=4, arith=1 -> data_o=0xF8000000.
- Extremes:
  - data_i=0x80000001, shamt=31: arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001.
  - Both complete in 32 cycles.
- Zero shift: shamt=0, data_i=0x12345678 -> done_o next cycle, data_o=0x12345678.
- Round trip with the left-shift-two block: x=0x0ABCDEF1, shift-left-two output 0x2AF37BC4 fed in with shamt=2, arith=0 -> data_o=0x0ABCDEF1.
- Busy protection and reset:
  - start_i held high with different operands during SHIFT/DONE -> result unchanged and no extra done_o. A new start is accepted the cycle after DONE.
  - rst_i=1 mid-SHIFT -> next cycle data_o=0, busy_o=0, no done_o pulse.
